dbus_arbiter: RTL and testbench
===============================

Name: dbus_arbiter

Overview:
- Shares the single ARM9-side data bus (ROM port B, RAM, UART, GPIO) between two masters: M0 = CPU data port, M1 = boot/debug loader (UART-driven RAM writer).
- Performs arbitration, address-region decode, slave chip-select generation, registered read-return routing, and unmapped-access error reporting.
- Replaces the ad-hoc region-select register and read mux in the top level.
- Sits between the masters and all data-bus slaves.

Parameters:
- HOLD_MAX, 8, maximum consecutive grants to one master while the other is requesting (4-bit counter; legal range 1..15).
- DEFAULT_RDATA, 32'hDEAD_BEEF, read data returned for unmapped addresses.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- m0_cen  in  1  M0 access request
- m0_wen  in  1  M0 write (1) / read (0)
- m0_addr  in  32  M0 byte address
- m0_wdata  in  32  M0 write data
- m0_flag  in  4  M0 byte enables
- m0_gnt  out  1  M0 access accepted this cycle
- m0_rdata  out  32  M0 read data
- m0_rvld  out  1  M0 read data valid
- m1_cen, m1_wen, m1_addr, m1_wdata, m1_flag, m1_gnt, m1_rdata, m1_rvld: same as M0, for M1
- s_wen  out  1  write strobe to slaves
- s_addr  out  32  address to slaves
- s_wdata  out  32  write data to slaves
- s_flag  out  4  byte enables to slaves
- s_sel  out  4  one-hot chip select: [0] RAM (addr[31:28]=4'h4), [1] ROM (4'h0), [2] UART (4'he), [3] GPIO (4'hd)
- rom_rdata, ram_rdata, uart_rdata, gpio_rdata  in  32 each  slave read data, valid one cycle after select
- err  out  1  one-cycle pulse on a granted access to an unmapped region

Behaviour:
- Single clock domain.
- Reset: state=IDLE, hold_cnt=0, rd_owner=0, rd_region=NONE, m*_rvld=0, err=0.
- FSM states IDLE, OWN0, OWN1; state is the current bus owner.
- Owner selection (combinational, per cycle):
  - IDLE: M0 if m0_cen, else M1 if m1_cen.
  - OWNx: keep x if mx_cen and not (other requesting and hold_cnt==HOLD_MAX); otherwise switch to the other master if it requests; otherwise go IDLE.
- Grant: mx_gnt = (selected owner==x) & mx_cen, same cycle. A master with cen high and gnt low must hold all of its request signals stable.
- hold_cnt:
  - resets to 1 on an owner change;
  - increments on a continued grant, saturating at HOLD_MAX;
  - holds when the other master is not requesting.
- Slave side:
  - s_addr, s_wdata, s_flag, s_wen are muxed from the granted master.
  - s_sel = region decode of the granted address; all zero when there is no grant.
  - s_wen is forced 0 when there is no grant.
- Read return:
  - On a granted read, register rd_owner and rd_region.
  - Next cycle, assert m{rd_owner}_rvld=1 and drive m{rd_owner}_rdata from the slave selected by rd_region.
  - Unmapped region returns DEFAULT_RDATA.
  - The non-owner master sees rdata=0, rvld=0.
- Writes produce no rvld.
- Latency: grant 0 cycles; read data 1 cycle after grant. Back-to-back reads are pipelined, one per cycle.
- Unmapped access:
  - no s_sel bit set; no slave write;
  - err pulses in the cycle after the grant;
  - reads still return rvld with DEFAULT_RDATA.
- Simultaneous requests from IDLE: M0 wins.
- After a forced switch, the losing master regains the bus only through the same fairness rule.
- Asynchronous reset mid-transfer: any pending rvld is dropped immediately and the FSM returns to IDLE.

Decomposition:
- Shared package holds:
  - region nibble constants: REG_ROM=4'h0, REG_RAM=4'h4, REG_GPIO=4'hd, REG_UART=4'he;
  - region index encoding: RAM=0, ROM=1, UART=2, GPIO=3, NONE;
  - FSM state encoding: IDLE, OWN0, OWN1.
- One sub-module, dbus_region_dec: purely combinational, address[31:28] to one-hot sel plus an unmapped flag.
  - Instantiated twice: once on the granted request, once for the registered read-return region.

Test Plan:
1. M0 only: read 0x4000_0010 with ram_rdata=32'h1234_5678.
   -> m0_gnt same cycle; s_sel=4'b0001; next cycle m0_rvld=1, m0_rdata=32'h1234_5678.
2. M0 and M1 both request from IDLE; M1 writes 0x4000_0000.
   -> M0 granted first; M1 m1_gnt=0 and holds its request.
   -> M1 granted once M0 deasserts cen; s_wen=1, s_flag=m1_flag.
3. Both masters request continuously, HOLD_MAX=8.
   -> grants alternate 8×M0, 8×M1, 8×M0; no cycle has both gnt high.
4. M1 reads 0x3000_0000 (unmapped).
   -> s_sel=0; next cycle err=1, m1_rvld=1, m1_rdata=32'hDEAD_BEEF.
5. Pipelined reads: M0 reads UART 0xE000_0000, then GPIO 0xD000_0000 on consecutive cycles.
   -> rdata returns uart_rdata then gpio_rdata on the next two cycles, rvld high for both.
6. Assert rst in the cycle after a granted read.
   -> m0_rvld=0 immediately, state=IDLE, no err.
   -> after rst release, a fresh request is granted normally.

Source files
------------

// File: rtl/dbus_arbiter_pkg.sv
// Shared definitions for the ARM9-side data-bus arbiter: region nibbles,
// region index encoding, owner FSM states and small conversion helpers.
package dbus_arbiter_pkg;

    localparam logic [3:0] REG_ROM  = 4'h0;
    localparam logic [3:0] REG_RAM  = 4'h4;
    localparam logic [3:0] REG_GPIO = 4'hd;
    localparam logic [3:0] REG_UART = 4'he;

    // Nibble that decodes to no slave; used to park the read-return decoder.
    localparam logic [3:0] REG_UNMAPPED = 4'hf;

    typedef enum logic [2:0] {
        RGN_RAM  = 3'd0,
        RGN_ROM  = 3'd1,
        RGN_UART = 3'd2,
        RGN_GPIO = 3'd3,
        RGN_NONE = 3'd4
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    function automatic region_e sel_to_region(input logic [3:0] sel);
        region_e r;
        case (sel)
            4'b0001: r = RGN_RAM;
            4'b0010: r = RGN_ROM;
            4'b0100: r = RGN_UART;
            4'b1000: r = RGN_GPIO;
            default: r = RGN_NONE;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] region_nibble(input region_e r);
        logic [3:0] nib;
        case (r)
            RGN_RAM:  nib = REG_RAM;
            RGN_ROM:  nib = REG_ROM;
            RGN_UART: nib = REG_UART;
            RGN_GPIO: nib = REG_GPIO;
            default:  nib = REG_UNMAPPED;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/dbus_arbiter_region_dec.sv
// Address-region decoder: top address nibble to one-hot slave select
// ([0] RAM, [1] ROM, [2] UART, [3] GPIO) plus an unmapped flag.
module dbus_region_dec
    import dbus_arbiter_pkg::*;
(
    input  logic [3:0] addr_hi,
    output logic [3:0] sel,
    output logic       unmapped
);

    always_comb begin
        sel      = 4'b0000;
        unmapped = 1'b0;
        case (addr_hi)
            REG_RAM:  sel = 4'b0001;
            REG_ROM:  sel = 4'b0010;
            REG_UART: sel = 4'b0100;
            REG_GPIO: sel = 4'b1000;
            default:  unmapped = 1'b1;
        endcase
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter with bounded-hold fairness, region decode,
// slave chip selects, registered read return and unmapped-access error.
//
// state   | meaning
// --------+------------------------------------------
// ST_IDLE | no master owned the bus last cycle
// ST_OWN0 | M0 (CPU data port) owned the bus last cycle
// ST_OWN1 | M1 (boot/debug loader) owned the bus last cycle
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_MAX      = 8,
    parameter logic [31:0] DEFAULT_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_cen,
    input  logic        m0_wen,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_flag,
    output logic        m0_gnt,
    output logic [31:0] m0_rdata,
    output logic        m0_rvld,

    input  logic        m1_cen,
    input  logic        m1_wen,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_flag,
    output logic        m1_gnt,
    output logic [31:0] m1_rdata,
    output logic        m1_rvld,

    output logic        s_wen,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_flag,
    output logic [3:0]  s_sel,

    input  logic [31:0] rom_rdata,
    input  logic [31:0] ram_rdata,
    input  logic [31:0] uart_rdata,
    input  logic [31:0] gpio_rdata,

    output logic        err
);

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    state_e      state_q, state_d;
    logic [3:0]  hold_cnt_q, hold_cnt_d;
    logic        rd_vld_q, rd_vld_d;
    logic        rd_owner_q, rd_owner_d;
    region_e     rd_region_q, rd_region_d;
    logic        err_q, err_d;

    logic        hold_hit;
    logic        gnt_any;
    logic        other_req;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_flag;
    logic [3:0]  req_sel;
    logic        req_unmapped;
    logic [3:0]  rd_nib;
    logic [3:0]  rd_sel;
    logic        rd_unmapped;
    logic [31:0] ret_data;

    assign hold_hit = (hold_cnt_q == HOLD_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The next state is also this cycle's selected owner.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_OWN0: begin
                if (m0_cen && !(m1_cen && hold_hit)) state_d = ST_OWN0;
                else if (m1_cen)                     state_d = ST_OWN1;
                else                                 state_d = ST_IDLE;
            end
            ST_OWN1: begin
                if (m1_cen && !(m0_cen && hold_hit)) state_d = ST_OWN1;
                else if (m0_cen)                     state_d = ST_OWN0;
                else                                 state_d = ST_IDLE;
            end
            default: begin
                if (m0_cen)      state_d = ST_OWN0;
                else if (m1_cen) state_d = ST_OWN1;
                else             state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        m0_gnt  = (state_d == ST_OWN0) && m0_cen;
        m1_gnt  = (state_d == ST_OWN1) && m1_cen;
        gnt_any = m0_gnt || m1_gnt;
    end

    always_comb begin
        if (m1_gnt) begin
            req_wen   = m1_wen;
            req_addr  = m1_addr;
            req_wdata = m1_wdata;
            req_flag  = m1_flag;
        end else begin
            req_wen   = m0_wen;
            req_addr  = m0_addr;
            req_wdata = m0_wdata;
            req_flag  = m0_flag;
        end
    end

    dbus_region_dec u_req_dec (
        .addr_hi  (req_addr[31:28]),
        .sel      (req_sel),
        .unmapped (req_unmapped)
    );

    always_comb begin
        s_addr  = req_addr;
        s_wdata = req_wdata;
        s_flag  = req_flag;
        s_sel   = gnt_any ? req_sel : 4'b0000;
        s_wen   = gnt_any && req_wen && !req_unmapped;
    end

    // Fairness counter only advances while the other master is waiting.
    always_comb begin
        other_req  = (state_d == ST_OWN0) ? m1_cen : m0_cen;
        hold_cnt_d = hold_cnt_q;
        if (state_d == ST_IDLE) begin
            hold_cnt_d = 4'd0;
        end else if (state_d != state_q) begin
            hold_cnt_d = 4'd1;
        end else if (other_req) begin
            hold_cnt_d = (hold_cnt_q >= HOLD_LIM) ? HOLD_LIM : hold_cnt_q + 4'd1;
        end
    end

    always_comb begin
        rd_vld_d    = gnt_any && !req_wen;
        rd_owner_d  = rd_owner_q;
        rd_region_d = rd_region_q;
        if (rd_vld_d) begin
            rd_owner_d  = m1_gnt;
            rd_region_d = sel_to_region(req_sel);
        end
        err_d = gnt_any && req_unmapped;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q  <= 4'd0;
            rd_vld_q    <= 1'b0;
            rd_owner_q  <= 1'b0;
            rd_region_q <= RGN_NONE;
            err_q       <= 1'b0;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            rd_vld_q    <= rd_vld_d;
            rd_owner_q  <= rd_owner_d;
            rd_region_q <= rd_region_d;
            err_q       <= err_d;
        end
    end

    assign rd_nib = region_nibble(rd_region_q);

    dbus_region_dec u_rd_dec (
        .addr_hi  (rd_nib),
        .sel      (rd_sel),
        .unmapped (rd_unmapped)
    );

    always_comb begin
        ret_data = DEFAULT_RDATA;
        if (!rd_unmapped) begin
            ret_data = ({32{rd_sel[0]}} & ram_rdata)
                     | ({32{rd_sel[1]}} & rom_rdata)
                     | ({32{rd_sel[2]}} & uart_rdata)
                     | ({32{rd_sel[3]}} & gpio_rdata);
        end
    end

    always_comb begin
        m0_rvld  = rd_vld_q && !rd_owner_q;
        m1_rvld  = rd_vld_q &&  rd_owner_q;
        m0_rdata = m0_rvld ? ret_data : 32'd0;
        m1_rdata = m1_rvld ? ret_data : 32'd0;
        err      = err_q;
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed scenarios followed by a randomized run
// checked against a transaction-level arbitration model.
module tb_dbus_arbiter;

    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cen, m0_wen, m1_cen, m1_wen;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_flag, m1_flag;
    logic        m0_gnt, m0_rvld, m1_gnt, m1_rvld;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_wen;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_flag, s_sel;
    logic [31:0] rom_rdata, ram_rdata, uart_rdata, gpio_rdata;
    logic        err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dbus_arbiter #(.HOLD_MAX(HOLD), .DEFAULT_RDATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst(rst),
        .m0_cen(m0_cen), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_flag(m0_flag), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvld(m0_rvld),
        .m1_cen(m1_cen), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_flag(m1_flag), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvld(m1_rvld),
        .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata), .s_flag(s_flag), .s_sel(s_sel),
        .rom_rdata(rom_rdata), .ram_rdata(ram_rdata), .uart_rdata(uart_rdata),
        .gpio_rdata(gpio_rdata), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_sel_of(input logic [3:0] nib);
        case (nib)
            4'h4:    return 4'b0001;
            4'h0:    return 4'b0010;
            4'he:    return 4'b0100;
            4'hd:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] exp_data_of(input logic [3:0] nib);
        case (nib)
            4'h4:    return ram_rdata;
            4'h0:    return rom_rdata;
            4'he:    return uart_rdata;
            4'hd:    return gpio_rdata;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // reference model state
    int          m_own, m_cnt, sel_own, p_own, nxt_own;
    bit          p_vld, p_err, nxt_vld, nxt_err, ow;
    logic [3:0]  p_nib, nxt_nib;
    logic        g_wen;
    logic [31:0] g_addr, g_wdata;
    logic [3:0]  g_flag;
    bit          w0, w1, mine, oth, last_g0, last_g1;
    logic [3:0]  nib_tab [6];

    initial begin
        nib_tab = '{4'h0, 4'h4, 4'hd, 4'he, 4'h3, 4'hf};
        rst = 1'b1;
        m0_cen = 0; m0_wen = 0; m0_addr = 0; m0_wdata = 0; m0_flag = 0;
        m1_cen = 0; m1_wen = 0; m1_addr = 0; m1_wdata = 0; m1_flag = 0;
        rom_rdata = 32'h0B0B_0001; ram_rdata = 32'h1234_5678;
        uart_rdata = 32'h0000_00A5; gpio_rdata = 32'h5A5A_0F0F;

        tick(); tick(); #2;
        chk("reset_m0_rvld", m0_rvld, 0);
        chk("reset_m1_rvld", m1_rvld, 0);
        chk("reset_err", err, 0);
        chk("reset_s_sel", s_sel, 0);
        chk("reset_s_wen", s_wen, 0);
        tick(); rst = 1'b0;

        // 1: M0 reads RAM
        tick(); m0_cen = 1; m0_wen = 0; m0_addr = 32'h4000_0010;
        #2;
        chk("t1_m0_gnt", m0_gnt, 1);
        chk("t1_s_sel", s_sel, 4'b0001);
        tick(); m0_cen = 0;
        #2;
        chk("t1_m0_rvld", m0_rvld, 1);
        chk("t1_m0_rdata", m0_rdata, 32'h1234_5678);
        chk("t1_m1_rvld", m1_rvld, 0);

        // 2: simultaneous request, M0 wins, M1 write waits
        tick(); m0_cen = 1; m0_addr = 32'h0000_0004;
        m1_cen = 1; m1_wen = 1; m1_addr = 32'h4000_0000; m1_wdata = 32'hA5A5_1234; m1_flag = 4'b0011;
        #2;
        chk("t2_m0_gnt", m0_gnt, 1);
        chk("t2_m1_gnt_wait", m1_gnt, 0);
        tick(); m0_cen = 0;
        #2;
        chk("t2_m1_gnt", m1_gnt, 1);
        chk("t2_s_wen", s_wen, 1);
        chk("t2_s_flag", s_flag, 4'b0011);
        chk("t2_s_addr", s_addr, 32'h4000_0000);
        chk("t2_s_wdata", s_wdata, 32'hA5A5_1234);
        chk("t2_m0_rom_rdata", m0_rdata, 32'h0B0B_0001);
        tick(); m1_cen = 0;
        #2;
        chk("t2_write_no_rvld", m1_rvld, 0);

        // 3: continuous contention alternates in blocks of HOLD
        for (int i = 0; i < 3 * HOLD; i++) begin
            tick();
            if (i == 0) begin
                m0_cen = 1; m0_wen = 0; m0_addr = 32'h4000_0100;
                m1_cen = 1; m1_wen = 0; m1_addr = 32'h4000_0200;
            end
            #2;
            chk("t3_m0_gnt", m0_gnt, ((i / HOLD) % 2) == 0);
            chk("t3_m1_gnt", m1_gnt, ((i / HOLD) % 2) == 1);
        end
        tick(); m0_cen = 0; m1_cen = 0;

        // 4: M1 unmapped read
        tick(); m1_cen = 1; m1_wen = 0; m1_addr = 32'h3000_0000;
        #2;
        chk("t4_m1_gnt", m1_gnt, 1);
        chk("t4_s_sel", s_sel, 0);
        tick(); m1_cen = 0;
        #2;
        chk("t4_err", err, 1);
        chk("t4_m1_rvld", m1_rvld, 1);
        chk("t4_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
        tick(); #2;
        chk("t4_err_pulse", err, 0);

        // 5: pipelined UART then GPIO reads
        tick(); m0_cen = 1; m0_wen = 0; m0_addr = 32'hE000_0000;
        #2;
        chk("t5_s_sel_uart", s_sel, 4'b0100);
        tick(); m0_addr = 32'hD000_0000;
        #2;
        chk("t5_rvld_uart", m0_rvld, 1);
        chk("t5_rdata_uart", m0_rdata, 32'h0000_00A5);
        tick(); m0_cen = 0;
        #2;
        chk("t5_rvld_gpio", m0_rvld, 1);
        chk("t5_rdata_gpio", m0_rdata, 32'h5A5A_0F0F);

        // 6: reset right after a granted read
        tick(); m0_cen = 1; m0_addr = 32'h4000_0020;
        #2;
        chk("t6_m0_gnt", m0_gnt, 1);
        tick(); m0_cen = 0; rst = 1'b1;
        #1;
        chk("t6_rvld_dropped", m0_rvld, 0);
        chk("t6_no_err", err, 0);
        tick(); rst = 1'b0;
        tick(); m1_cen = 1; m1_wen = 0; m1_addr = 32'h4000_0040;
        m0_cen = 1; m0_addr = 32'h4000_0020;
        #2;
        chk("t6_idle_m0_wins", m0_gnt, 1);
        chk("t6_idle_m1_waits", m1_gnt, 0);
        tick(); m0_cen = 0; m1_cen = 0;
        #2;
        chk("t6_fresh_rvld", m0_rvld, 1);
        chk("t6_fresh_rdata", m0_rdata, 32'h1234_5678);

        // randomized phase from a clean reset
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        m_own = 0; m_cnt = 0; sel_own = 0; ow = 0;
        nxt_vld = 0; nxt_err = 0; nxt_own = 0; nxt_nib = 0;
        last_g0 = 0; last_g1 = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            if (sel_own == 0) begin
                m_own = 0; m_cnt = 0;
            end else if (sel_own != m_own) begin
                m_own = sel_own; m_cnt = 1;
            end else if (ow) begin
                m_cnt = (m_cnt < HOLD) ? m_cnt + 1 : HOLD;
            end
            p_vld = nxt_vld; p_own = nxt_own; p_nib = nxt_nib; p_err = nxt_err;
            #1;
            rom_rdata = $urandom; ram_rdata = $urandom; uart_rdata = $urandom; gpio_rdata = $urandom;
            if (!(m0_cen && !last_g0)) begin
                m0_cen = ($urandom_range(0, 3) != 0); m0_wen = $urandom_range(0, 1);
                m0_addr = {nib_tab[$urandom_range(0, 5)], 28'($urandom)};
                m0_wdata = $urandom; m0_flag = 4'($urandom);
            end
            if (!(m1_cen && !last_g1)) begin
                m1_cen = ($urandom_range(0, 3) != 0); m1_wen = $urandom_range(0, 1);
                m1_addr = {nib_tab[$urandom_range(0, 5)], 28'($urandom)};
                m1_wdata = $urandom; m1_flag = 4'($urandom);
            end
            w0 = m0_cen; w1 = m1_cen;
            if (m_own == 0) begin
                sel_own = w0 ? 1 : (w1 ? 2 : 0);
            end else begin
                mine = (m_own == 1) ? w0 : w1;
                oth  = (m_own == 1) ? w1 : w0;
                if (mine && !(oth && m_cnt == HOLD)) sel_own = m_own;
                else if (oth)                        sel_own = 3 - m_own;
                else                                 sel_own = 0;
            end
            ow = (sel_own == 1) ? w1 : w0;
            g_wen = (sel_own == 2) ? m1_wen : m0_wen;
            g_addr = (sel_own == 2) ? m1_addr : m0_addr;
            g_wdata = (sel_own == 2) ? m1_wdata : m0_wdata;
            g_flag = (sel_own == 2) ? m1_flag : m0_flag;
            nxt_vld = (sel_own != 0) && !g_wen;
            nxt_own = sel_own;
            nxt_nib = g_addr[31:28];
            nxt_err = (sel_own != 0) && (exp_sel_of(g_addr[31:28]) == 4'b0000);
            #2;
            chk("rnd_m0_gnt", m0_gnt, sel_own == 1);
            chk("rnd_m1_gnt", m1_gnt, sel_own == 2);
            chk("rnd_s_sel", s_sel, (sel_own != 0) ? exp_sel_of(g_addr[31:28]) : 4'b0000);
            chk("rnd_s_wen", s_wen, (sel_own != 0) && g_wen && !nxt_err);
            if (sel_own != 0) begin
                chk("rnd_s_addr", s_addr, g_addr);
                chk("rnd_s_wdata", s_wdata, g_wdata);
                chk("rnd_s_flag", s_flag, g_flag);
            end
            chk("rnd_m0_rvld", m0_rvld, p_vld && p_own == 1);
            chk("rnd_m1_rvld", m1_rvld, p_vld && p_own == 2);
            chk("rnd_m0_rdata", m0_rdata, (p_vld && p_own == 1) ? exp_data_of(p_nib) : 32'd0);
            chk("rnd_m1_rdata", m1_rdata, (p_vld && p_own == 2) ? exp_data_of(p_nib) : 32'd0);
            chk("rnd_err", err, p_err);
            last_g0 = (sel_own == 1);
            last_g1 = (sel_own == 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
